// File: rtl/sram_bus_arbiter.sv
// Arbitrates one SRAM-like bus between the IF fetch port and the MEM load/store port,
// one transaction at a time, with a per-transaction timeout and pipeline stall requests.
module sram_bus_arbiter #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic        bus_err
);

  localparam int unsigned CW    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned LIMIT = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_e;

  typedef struct packed {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  owner_e          last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  bus_cmd_t        cmd_q, cmd_d;
  logic            bus_req_q, bus_req_d;
  logic            inst_addr_ok_q, inst_addr_ok_d;
  logic            data_addr_ok_q, data_addr_ok_d;
  logic            inst_data_ok_q, inst_data_ok_d;
  logic            data_data_ok_q, data_data_ok_d;
  logic            bus_err_q, bus_err_d;
  logic [31:0]     inst_rdata_q, inst_rdata_d;
  logic [31:0]     data_rdata_q, data_rdata_d;

  logic            inst_cand, data_cand;
  logic            done, abort, timeout;
  logic [31:0]     ret_data;

  // A requester's req seen alongside its own data_ok belongs to the finished transaction
  assign inst_cand = inst_req & ~inst_data_ok_q;
  assign data_cand = data_req & ~data_data_ok_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_NONE;
      last_q         <= OWN_INST;
      cnt_q          <= '0;
      cmd_q          <= '0;
      bus_req_q      <= 1'b0;
      inst_addr_ok_q <= 1'b0;
      data_addr_ok_q <= 1'b0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      bus_err_q      <= 1'b0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      cmd_q          <= cmd_d;
      bus_req_q      <= bus_req_d;
      inst_addr_ok_q <= inst_addr_ok_d;
      data_addr_ok_q <= data_addr_ok_d;
      inst_data_ok_q <= inst_data_ok_d;
      data_data_ok_q <= data_data_ok_d;
      bus_err_q      <= bus_err_d;
      inst_rdata_q   <= inst_rdata_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    cmd_d          = cmd_q;
    bus_req_d      = bus_req_q;
    inst_addr_ok_d = 1'b0;
    data_addr_ok_d = 1'b0;
    inst_data_ok_d = 1'b0;
    data_data_ok_d = 1'b0;
    bus_err_d      = 1'b0;
    inst_rdata_d   = inst_rdata_q;
    data_rdata_d   = data_rdata_q;
    done           = (state_q == WAIT) && bus_data_ok;
    timeout        = (MAX_WAIT != 0) && (cnt_q == CW'(LIMIT));
    abort          = 1'b0;
    ret_data       = '0;

    case (state_q)
      IDLE: begin
        if (inst_cand || data_cand) begin
          bus_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = ADDR;
          if (data_cand && (!inst_cand || last_q == OWN_INST)) begin
            owner_d     = OWN_DATA;
            cmd_d.wr    = data_wr;
            cmd_d.wstrb = data_wr ? data_wstrb : 4'b0000;
            cmd_d.addr  = data_addr;
            cmd_d.wdata = data_wr ? data_wdata : 32'h0;
          end else begin
            owner_d     = OWN_INST;
            cmd_d.wr    = 1'b0;
            cmd_d.wstrb = 4'b0000;
            cmd_d.addr  = inst_addr;
            cmd_d.wdata = 32'h0;
          end
        end
      end
      ADDR, WAIT: begin
        abort = !done && timeout;
        if (done || abort) begin
          // Completion or timeout: return to IDLE and hand the result to the owner
          ret_data  = (done && !cmd_q.wr) ? bus_rdata : 32'h0;
          state_d   = IDLE;
          bus_req_d = 1'b0;
          last_d    = owner_q;
          owner_d   = OWN_NONE;
          bus_err_d = abort;
          if (owner_q == OWN_DATA) begin
            data_data_ok_d = 1'b1;
            data_rdata_d   = ret_data;
          end else begin
            inst_data_ok_d = 1'b1;
            inst_rdata_d   = ret_data;
          end
        end else begin
          if (MAX_WAIT != 0) cnt_d = cnt_q + CW'(1);
          if (state_q == ADDR && bus_addr_ok) begin
            state_d   = WAIT;
            bus_req_d = 1'b0;
            if (owner_q == OWN_DATA) data_addr_ok_d = 1'b1;
            else                     inst_addr_ok_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inst_addr_ok = inst_addr_ok_q;
  assign inst_data_ok = inst_data_ok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_addr_ok = data_addr_ok_q;
  assign data_data_ok = data_data_ok_q;
  assign data_rdata   = data_rdata_q;
  assign bus_req      = bus_req_q;
  assign bus_wr       = cmd_q.wr;
  assign bus_wstrb    = cmd_q.wstrb;
  assign bus_addr     = cmd_q.addr;
  assign bus_wdata    = cmd_q.wdata;
  assign bus_err      = bus_err_q;
  assign stallreq_if  = inst_req & ~inst_data_ok_q;
  assign stallreq_mem = data_req & ~data_data_ok_q;

endmodule
